// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine over a 256x64 registered-read memory,
// with byte-masked stores done as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_write,
  output logic [7:0]  mem_addr,
  output logic [63:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [63:0] mem_read_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DATA, RESP} state_t;
  state_t state, state_nx;
  logic        l_write;
  logic [7:0]  l_addr, l_mask, held_addr;
  logic [63:0] l_wdata, merged;
  logic        accept, busy, rmw;
  assign accept     = req_valid && req_ready;
  assign busy       = state == WRITE || state == READ || state == DATA;
  assign rmw        = state == DATA && l_write;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_write = l_write;
  // byte k occupies the k-th byte counting from the most significant end
  for (genvar k = 0; k < 8; k++) begin : g_merge
    assign merged[63-8*k -: 8] = l_mask[k] ? l_wdata[63-8*k -: 8] : mem_read_data[63-8*k -: 8];
  end
  always_comb begin
    state_nx         = state;
    mem_write_enable = state == WRITE || rmw;
    mem_write_data   = state == WRITE ? l_wdata : rmw ? merged : '0;
    mem_addr         = busy ? l_addr : held_addr;
    case (state)
      IDLE:  if (req_valid) state_nx = !req_write ? READ :
                                       req_mask == 8'hFF ? WRITE :
                                       req_mask == 8'h00 ? RESP : READ;
      WRITE: state_nx = RESP;
      READ:  state_nx = DATA;
      DATA:  state_nx = RESP;
      RESP:  if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      l_write    <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_mask     <= '0;
      held_addr  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        l_write <= req_write;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_mask  <= req_mask;
      end
      if (busy) held_addr <= l_addr;
      if (state == DATA) resp_rdata <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests against a word/byte-level memory model,
// with a queue-based scoreboard checked by an independent response monitor.
module tb_load_store_unit;
  logic        clk = 0, rst = 1, req_valid = 0, req_write = 0, resp_ready = 1;
  logic [7:0]  req_addr = 0, req_mask = 0;
  logic [63:0] req_wdata = 0, mem_read_data = 0;
  logic        req_ready, resp_valid, resp_write, mem_write_enable;
  logic [63:0] resp_rdata, mem_write_data;
  logic [7:0]  mem_addr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_write(resp_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  typedef struct {
    logic [63:0] rdata;
    bit          chk_rdata;
    logic        wr;
    int          lat;
    int          acc;
    int          wbase;
    int          nwr;
  } item_t;

  item_t       q[$];
  item_t       m_it;
  logic [63:0] mem[256];
  logic [63:0] ref_mem[256];
  int          cyc = 0, wr_cnt = 0, checks = 0, failures = 0, first = 0;
  bit          rand_rdy = 0, seen = 0, pend = 0, bad = 0;
  logic [63:0] h_rd;
  logic        h_wr;

  always @(posedge clk) cyc++;

  // memory environment: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    mem_read_data <= mem[mem_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r = old;
    logic [63:0] sel;
    for (int k = 0; k < 8; k++)
      if (m[k]) begin
        sel = 64'hFF << (56 - 8 * k);
        r = (r & ~sel) | (d & sel);
      end
    return r;
  endfunction

  function automatic item_t model(input logic w, input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
    item_t it;
    it.rdata = '0; it.chk_rdata = 0; it.wr = w; it.nwr = 0; it.lat = 1; it.acc = 0; it.wbase = 0;
    if (!w) begin
      it.rdata = ref_mem[a]; it.chk_rdata = 1; it.lat = 3;
    end else if (m == 8'hFF) begin
      ref_mem[a] = d; it.nwr = 1; it.lat = 2;
    end else if (m != 8'h00) begin
      it.rdata = ref_mem[a]; it.chk_rdata = 1; it.lat = 3; it.nwr = 1;
      ref_mem[a] = merge(ref_mem[a], d, m);
    end
    return it;
  endfunction

  task automatic issue(input logic w, input logic [7:0] a, input logic [63:0] d, input logic [7:0] m,
                       input bit hold, output int acc);
    item_t it;
    int n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_mask = m;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    it = model(w, a, d, m);
    it.acc = cyc;
    it.wbase = wr_cnt;
    q.push_back(it);
    // post-acceptance input changes must not leak into the in-flight request
    req_write = 1'($urandom_range(0, 1));
    req_addr = 8'($urandom);
    req_wdata = {$urandom, $urandom};
    req_mask = 8'($urandom);
    if (!hold) req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || resp_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_resp_write"}, 64'(resp_write), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_write_enable), 64'd0);
  endtask

  // response monitor: latency, data, stability under backpressure, write count, return to idle
  always @(negedge clk) begin
    if (!rst) begin
      seen = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("idle_after_resp", {62'd0, req_ready, resp_valid}, 64'd2);
        pend = 0;
      end
      if (resp_valid) begin
        if (!seen) begin
          seen = 1; first = cyc; h_rd = resp_rdata; h_wr = resp_write; bad = 0;
        end else if (resp_rdata !== h_rd || resp_write !== h_wr) bad = 1;
        if (req_ready !== 1'b0 || mem_write_enable !== 1'b0 || mem_write_data !== 64'd0) bad = 1;
        if (resp_ready) begin
          if (q.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
          else begin
            m_it = q.pop_front();
            if (m_it.chk_rdata) chk("resp_rdata", resp_rdata, m_it.rdata);
            chk("resp_write", 64'(resp_write), 64'(m_it.wr));
            chk("latency", 64'(first + 1 - m_it.acc), 64'(m_it.lat));
            chk("mem_writes", 64'(wr_cnt - m_it.wbase), 64'(m_it.nwr));
            chk("resp_stable", 64'(bad), 64'd0);
          end
          seen = 0;
          pend = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, rel, wc, n;
    logic [63:0] sv;
    logic w;
    logic [7:0] a, m;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 64'h9E3779B97F4A7C15 * 64'(i + 1);
      ref_mem[i] = mem[i];
    end
    #1 rst = 0;
    #2 reset_checks("rst");
    @(negedge clk);
    rel = cyc;
    rst = 1;
    issue(1, 8'h05, 64'h0123456789ABCDEF, 8'hFF, 0, acc);
    chk("first_accept_cycle", 64'(acc), 64'(rel + 1));
    drain();
    chk("mem05_full_store", mem[5], 64'h0123456789ABCDEF);
    issue(0, 8'h05, 64'd0, 8'h00, 0, acc);
    drain();
    issue(1, 8'h05, '1, 8'b1000_0001, 0, acc);
    drain();
    chk("mem05_partial_store", mem[5], 64'hFF23456789ABCDFF);
    issue(0, 8'h05, 64'd0, 8'h00, 0, acc);
    drain();
    issue(1, 8'hFF, 64'hA5A5_0F0F_C3C3_1234, 8'hFF, 0, acc);
    issue(0, 8'h00, 64'd0, 8'h00, 0, acc);
    issue(0, 8'hFF, 64'd0, 8'h00, 0, acc);
    issue(1, 8'h00, 64'h1111_2222_3333_4444, 8'h3C, 0, acc);
    drain();
    resp_ready = 0;
    issue(0, 8'h05, 64'd0, 8'h00, 0, acc);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1 resp_ready = 1;
    drain();
    sv = mem[8'h10];
    wc = wr_cnt;
    issue(1, 8'h10, {$urandom, $urandom}, 8'h00, 0, acc);
    drain();
    chk("mem10_unchanged", mem[8'h10], sv);
    chk("zero_mask_no_write", 64'(wr_cnt), 64'(wc));
    sv = ref_mem[8'h20];
    wc = wr_cnt;
    issue(1, 8'h20, '1, 8'h0F, 0, acc);
    #1 rst = 0;
    #1 reset_checks("midrst");
    q.delete();
    ref_mem[8'h20] = sv;
    repeat (2) @(negedge clk);
    rel = cyc;
    rst = 1;
    issue(0, 8'h20, 64'd0, 8'h00, 0, acc);
    chk("accept_after_rst", 64'(acc), 64'(rel + 1));
    drain();
    chk("mem20_no_write", mem[8'h20], sv);
    chk("rst_no_write", 64'(wr_cnt), 64'(wc));
    for (int i = 0; i < 4; i++) issue(0, 8'(i), 64'd0, 8'h00, i < 3, acc);
    drain();
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      n = $urandom_range(0, 3);
      m = n == 0 ? 8'hFF : n == 1 ? 8'h00 : 8'($urandom);
      issue(w, a, {$urandom, $urandom}, m, i < 59 && $urandom_range(0, 1) == 1, acc);
    end
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #2 resp_ready = 1;
    for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports, clock and reset first:
clk  in  1  clock; all state changes on posedge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  8  word address, 256 x 64-bit words.
req_wdata  in  64  store data, bit 0 = MSB, byte k = bits [8k:8k+7].
req_mask  in  8  store byte enables; bit k enables byte k; ignored for loads.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  64  load data; for partial stores, the pre-merge word.
resp_write  out  1  echoes req_write of the completed request.
mem_addr  out  8  memory word address.
mem_write_data  out  64  memory write data.
mem_write_enable  out  1  memory write strobe.
mem_read_data  in  64  memory read data, registered: valid the cycle after mem_addr is presented.

Function
REQ-002 SHALL implement the FSM states IDLE, WRITE, READ, DATA and RESP, with exactly one request in flight.
REQ-003 SHALL assert req_ready only in IDLE; a request is accepted on a posedge where req_valid and req_ready are both 1.
REQ-004 SHALL latch req_write, req_addr, req_wdata and req_mask on acceptance; input changes after acceptance SHALL have no effect.
REQ-005 After acceptance the next state SHALL be:
- WRITE for a store with mask 8'hFF;
- RESP for a store with mask 8'h00 (no memory access);
- READ for all other requests.
REQ-006 In WRITE: mem_addr = latched addr, mem_write_data = latched wdata, mem_write_enable = 1; next state RESP.
REQ-007 In READ: mem_addr = latched addr, mem_write_enable = 0; next state DATA.
REQ-008 In DATA, for a load: capture mem_read_data into resp_rdata; next state RESP.
REQ-009 In DATA, for a partial store: drive mem_write_enable = 1 and mem_addr = latched addr; next state RESP.
- mem_write_data byte k = wdata byte k where mask[k] = 1, otherwise mem_read_data byte k.
- capture mem_read_data into resp_rdata.
REQ-010 In RESP: resp_valid = 1 and resp_rdata / resp_write held stable; on resp_ready = 1, go to IDLE.
- resp_valid and resp_rdata SHALL remain unchanged while resp_ready = 0.
REQ-011 mem_write_enable SHALL be 1 only in WRITE, and in DATA for a partial store; at most one memory write per request.
REQ-012 Outside WRITE, READ and DATA, mem_addr SHALL hold its last value and mem_write_data SHALL be 0.
REQ-013 Latency from acceptance edge to resp_valid high: full store 2 cycles; load or partial store 3 cycles; zero-mask store 1 cycle.
REQ-014 A new request SHALL NOT be accepted in the cycle resp_valid drops; the earliest acceptance is the following cycle, in IDLE.
REQ-015 A store to address 8'hFF and a load from 8'h00 SHALL behave identically to any other address; there is no address wrap or increment.

Reset
REQ-016 While rst = 0, SHALL immediately force:
- state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_write = 0;
- mem_addr = 0, mem_write_data = 0, mem_write_enable = 0;
- all latched request registers = 0.
REQ-017 Reset asserted mid-request SHALL abandon that request with no response; a write not yet issued SHALL NOT occur.
REQ-018 The first request SHALL be accepted on the first posedge after rst rises with req_valid = 1.

Verification
REQ-019 Full store then load:
- store addr 8'h05, data 64'h0123456789ABCDEF, mask FF -> one write cycle, resp_valid 2 cycles after acceptance;
- then load 8'h05 -> resp_rdata 64'h0123456789ABCDEF, 3 cycles after acceptance.
REQ-020 Partial store:
- with word 8'h05 = 64'h0123456789ABCDEF, store data 64'hFFFF..FF, mask 8'b1000_0001;
- -> resp_rdata 64'h0123456789ABCDEF; a following load returns 64'hFF23456789ABCDFF.
REQ-021 Backpressure: load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready = 0 throughout; IDLE one cycle after resp_ready rises.
REQ-022 Zero-mask store to 8'h10 -> mem_write_enable never asserted, word unchanged, resp_valid 1 cycle after acceptance.
REQ-023 Reset while in READ of a partial store to 8'h20 -> no write occurs, all outputs at REQ-016 values, next request accepted normally.
REQ-024 Back-to-back: req_valid held high with 4 queued loads to 8'h00..8'h03 and resp_ready = 1 -> each accepted only in IDLE, responses in order with correct data.
